// File: rtl/core_run_pkg.sv
// core_run_pkg: shared state, status codes and retire popcount for the run controller
package core_run_pkg;

    typedef enum logic [1:0] {IDLE, RESET, RUN, FINISH} run_state_t;

    localparam logic [1:0] ST_NONE    = 2'd0;
    localparam logic [1:0] ST_PASS    = 2'd1;
    localparam logic [1:0] ST_FAIL    = 2'd2;
    localparam logic [1:0] ST_TIMEOUT = 2'd3;

    localparam int MAX_CORES = 16;

    function automatic logic [4:0] popcount(input logic [MAX_CORES-1:0] v);
        popcount = '0;
        for (int i = 0; i < MAX_CORES; i++) popcount = popcount + 5'(v[i]);
    endfunction

endpackage

// File: rtl/core_run_sat_cnt.sv
// core_run_sat_cnt: clearable counter that adds a variable amount and sticks at all ones
module core_run_sat_cnt #(
    parameter int W  = 32,
    parameter int IW = 5
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          clr,
    input  logic [IW-1:0] inc,
    output logic [W-1:0]  q
);

    localparam int SW = (W > IW ? W : IW) + 1;

    logic [SW-1:0] sum;

    assign sum = SW'(q) + SW'(inc);

    // clear wins over counting; a sum past the top clamps to all ones
    always_ff @(posedge clk or negedge arst_n)
        if (!arst_n) q <= '0;
        else q <= clr ? '0 : (sum > SW'({W{1'b1}}) ? {W{1'b1}} : sum[W-1:0]);

endmodule

// File: rtl/core_run_ctrl.sv
// core_run_ctrl: sequences reset pulse and execution of the cores and judges the run outcome
module core_run_ctrl
    import core_run_pkg::*;
#(
    parameter int NUM_CORES      = 1,
    parameter int RST_CYCLES     = 1,
    parameter int TIMEOUT_CYCLES = 20,
    parameter int CNT_W          = 32,
    parameter int CODE_W         = 8,
    localparam int FW            = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1
) (
    input  logic                        clk,
    input  logic                        arst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic [NUM_CORES-1:0]        halt_valid,
    input  logic [NUM_CORES*CODE_W-1:0] halt_code,
    input  logic [NUM_CORES-1:0]        retire,
    output logic                        core_srst,
    output logic                        busy,
    output logic                        done,
    output logic [1:0]                  status,
    output logic [FW-1:0]               fail_core,
    output logic [CODE_W-1:0]           fail_code,
    output logic [CNT_W-1:0]            cycle_cnt,
    output logic [CNT_W-1:0]            retire_cnt
);

    localparam int RW = RST_CYCLES > 1 ? $clog2(RST_CYCLES) : 1;

    run_state_t           state;
    logic [RW-1:0]        rst_cnt;
    logic [NUM_CORES-1:0] halted;
    logic [NUM_CORES-1:0] new_halt;
    logic                 run_ok;
    logic                 clr;
    logic                 fail_hit;
    logic                 pass_hit;
    logic                 timeout_hit;
    logic [FW-1:0]        fail_idx;
    logic [CODE_W-1:0]    fail_val;
    logic [4:0]           retire_num;

    assign run_ok      = state == RUN && !abort;
    assign clr         = start && (state == IDLE || state == FINISH);
    assign new_halt    = halt_valid & ~halted;
    assign pass_hit    = &(halted | halt_valid);
    assign timeout_hit = cycle_cnt == CNT_W'(TIMEOUT_CYCLES - 1);
    assign retire_num  = run_ok ? popcount(MAX_CORES'(retire)) : 5'd0;

    // lowest-indexed core that newly halts with a nonzero code is the reported failure
    always_comb begin
        fail_hit = 1'b0;
        fail_idx = '0;
        fail_val = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--)
            if (new_halt[i] && halt_code[i*CODE_W +: CODE_W] != '0) begin
                fail_hit = 1'b1;
                fail_idx = FW'(i);
                fail_val = halt_code[i*CODE_W +: CODE_W];
            end
    end

    core_run_sat_cnt #(.W(CNT_W), .IW(1)) u_cycle_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .clr    (clr),
        .inc    (run_ok),
        .q      (cycle_cnt)
    );

    core_run_sat_cnt #(.W(CNT_W), .IW(5)) u_retire_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .clr    (clr),
        .inc    (retire_num),
        .q      (retire_cnt)
    );

    // run sequencer with registered outputs; abort beats any end condition in the same cycle
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state     <= IDLE;
            rst_cnt   <= '0;
            halted    <= '0;
            core_srst <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            status    <= ST_NONE;
            fail_core <= '0;
            fail_code <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, FINISH: if (start) begin
                    state     <= RESET;
                    rst_cnt   <= '0;
                    halted    <= '0;
                    busy      <= 1'b1;
                    status    <= ST_NONE;
                    fail_core <= '0;
                    fail_code <= '0;
                end
                RESET: if (abort) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else if (rst_cnt == RW'(RST_CYCLES - 1)) begin
                    state     <= RUN;
                    core_srst <= 1'b0;
                end else begin
                    rst_cnt <= rst_cnt + 1'b1;
                end
                default: if (abort) begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    core_srst <= 1'b1;
                end else begin
                    halted <= halted | halt_valid;
                    if (fail_hit || pass_hit || timeout_hit) begin
                        state     <= FINISH;
                        busy      <= 1'b0;
                        core_srst <= 1'b1;
                        done      <= 1'b1;
                        status    <= fail_hit ? ST_FAIL : (pass_hit ? ST_PASS : ST_TIMEOUT);
                        fail_core <= fail_hit ? fail_idx : '0;
                        fail_code <= fail_hit ? fail_val : '0;
                    end
                end
            endcase
        end
    end

endmodule
